// File: rtl/apb_master.sv
// apb_master: single-outstanding APB4 requester; valid/ready command in, valid/ready response out.
// Optional ACCESS wait-state timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int ADDR_WD     = 32,
  parameter int DATA_WD     = 32,
  parameter int STRB_WD     = 4,
  parameter int PROT_WD     = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               b_pclk,
  input  logic               b_prst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  input  logic [STRB_WD-1:0] cmd_strb,
  input  logic [PROT_WD-1:0] cmd_prot,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               b_psel,
  output logic               b_penable,
  output logic               b_pwrite,
  output logic [ADDR_WD-1:0] b_paddr,
  output logic [DATA_WD-1:0] b_pwdata,
  output logic [PROT_WD-1:0] b_pprot,
  output logic [STRB_WD-1:0] b_pstrb,
  input  logic [DATA_WD-1:0] b_prdata,
  input  logic               b_pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   access_ok;
  logic   access_abort;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYC must be in 1..65535");
  end

  // cmd_ready is only ever high in IDLE, so it alone qualifies the accept.
  assign accept    = cmd_valid && cmd_ready;
  assign access_ok = (state == ACCESS) && b_pready;

  always_ff @(posedge b_pclk) begin
    if (b_prst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_ok || access_abort) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they are registered yet cycle-exact.
  always_ff @(posedge b_pclk) begin
    if (b_prst) begin
      cmd_ready <= 1'b0;
      b_psel    <= 1'b0;
      b_penable <= 1'b0;
      rsp_valid <= 1'b0;
      b_pwrite  <= 1'b0;
      b_paddr   <= '0;
      b_pwdata  <= '0;
      b_pprot   <= '0;
      b_pstrb   <= '0;
      rsp_rdata <= '0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      b_psel    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      b_penable <= (state_nxt == ACCESS);
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        b_pwrite <= cmd_write;
        b_paddr  <= cmd_addr;
        b_pwdata <= cmd_wdata;
        b_pprot  <= cmd_prot;
        b_pstrb  <= cmd_write ? cmd_strb : '0;
      end
      if (access_ok) begin
        rsp_rdata <= b_pwrite ? '0 : b_prdata;
      end else if (access_abort) begin
        rsp_rdata <= '0;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_cnt;

  // Held at zero outside ACCESS, so it starts from zero on every ACCESS entry.
  always_ff @(posedge b_pclk) begin
    if (b_prst || state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!b_pready) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // A ready completer on the limiting edge wins over the abort.
  assign access_abort = (state == ACCESS) && !b_pready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge b_pclk) begin
    if (b_prst) begin
      rsp_err <= 1'b0;
    end else if (access_ok) begin
      rsp_err <= 1'b0;
    end else if (access_abort) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign access_abort = 1'b0;
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a transaction-level timeline model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_apb_master;
  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb  = '0;
  logic [2:0]  cmd_prot  = '0;
  logic        rsp_ready = 1'b0;
  logic        pready    = 1'b0;

  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        b_psel, b_penable, b_pwrite;
  logic [31:0] b_paddr, b_pwdata, b_prdata;
  logic [2:0]  b_pprot;
  logic [3:0]  b_pstrb;

  logic [31:0] mem [16] = '{default: 32'h0};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  apb_master #(
    .ADDR_WD(32), .DATA_WD(32), .STRB_WD(4), .PROT_WD(3), .TIMEOUT_CYC(TO)
  ) dut (
    .b_pclk(clk), .b_prst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite), .b_paddr(b_paddr),
    .b_pwdata(b_pwdata), .b_pprot(b_pprot), .b_pstrb(b_pstrb),
    .b_prdata(b_prdata), .b_pready(pready)
  );

  // Simple completer: 16-word memory with byte strobes.
  assign b_prdata = b_psel ? mem[b_paddr[5:2]] : 32'h0;
  always @(posedge clk) begin
    if (b_psel && b_penable && pready && b_pwrite) begin
      for (int i = 0; i < 4; i++)
        if (b_pstrb[i]) mem[b_paddr[5:2]][8*i +: 8] <= b_pwdata[8*i +: 8];
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: cycle k is the interval after rising edge k.  A transfer
  // accepted on edge t_acc has SETUP in cycle t_acc, ACCESS from t_acc+1 until
  // the completing edge t_done, RESP from t_done until the rsp handshake edge.
  bit          m_rdy_ok = 1'b0;
  bit          m_busy   = 1'b0;
  bit          m_done   = 1'b0;
  int          t_acc    = 0;
  int          t_done   = 0;
  logic        e_write  = 1'b0;
  logic [31:0] e_addr   = '0;
  logic [31:0] e_wdata  = '0;
  logic [2:0]  e_prot   = '0;
  logic [3:0]  e_strb   = '0;
  logic [31:0] e_rdata  = '0;
  logic        e_err    = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_rdy_ok = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      e_write = 1'b0; e_addr = '0; e_wdata = '0; e_prot = '0; e_strb = '0;
      e_rdata = '0; e_err = 1'b0;
    end else begin
      if (m_busy && m_done && cyc > t_done) begin
        if (rsp_ready) begin
          m_busy = 1'b0;
          m_done = 1'b0;
        end
      end else if (m_busy && !m_done && cyc >= t_acc + 2) begin
        if (pready) begin
          m_done = 1'b1; t_done = cyc; e_err = 1'b0;
          e_rdata = e_write ? 32'h0 : b_prdata;
        end else if (TO_ON && (cyc - t_acc - 1 == TO)) begin
          m_done = 1'b1; t_done = cyc; e_err = 1'b1; e_rdata = 32'h0;
        end
      end else if (!m_busy && m_rdy_ok && cmd_valid) begin
        m_busy = 1'b1; t_acc = cyc;
        e_write = cmd_write; e_addr = cmd_addr; e_wdata = cmd_wdata; e_prot = cmd_prot;
        e_strb = cmd_write ? cmd_strb : 4'h0;
      end
      m_rdy_ok = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk1("cmp_cmd_ready", cmd_ready, m_rdy_ok && !m_busy);
      chk1("cmp_psel", b_psel, m_busy && !m_done);
      chk1("cmp_penable", b_penable, m_busy && !m_done && cyc >= t_acc + 1);
      chk1("cmp_rsp_valid", rsp_valid, m_busy && m_done);
      chk1("cmp_pwrite", b_pwrite, e_write);
      chk32("cmp_paddr", b_paddr, e_addr);
      chk32("cmp_pwdata", b_pwdata, e_wdata);
      chk32("cmp_pprot", {29'h0, b_pprot}, {29'h0, e_prot});
      chk32("cmp_pstrb", {28'h0, b_pstrb}, {28'h0, e_strb});
      chk32("cmp_rsp_rdata", rsp_rdata, e_rdata);
      chk1("cmp_rsp_err", rsp_err, e_err);
    end
  end

  // Present one command when cmd_ready is seen; returns the accept cycle N.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, output int n);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_wait: cmd_ready never rose, got %b want 1 (cycle %0d)", cmd_ready, cyc);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    n = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 10000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_psel", b_psel, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_paddr", b_paddr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk1("rel_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write
    rsp_ready = 1'b1; pready = 1'b1;
    send(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'd2, n);
    chk1("t1_psel_n1", b_psel, 1'b1);
    chk1("t1_penable_n1", b_penable, 1'b0);
    chk32("t1_pstrb_n1", {28'h0, b_pstrb}, 32'hF);
    @(negedge clk);
    chk1("t1_penable_n2", b_penable, 1'b1);
    chk1("t1_rsp_valid_n2", rsp_valid, 1'b0);
    @(negedge clk);
    chk1("t1_rsp_valid_n3", rsp_valid, 1'b1);
    chk1("t1_rsp_err_n3", rsp_err, 1'b0);
    chk1("t1_psel_n3", b_psel, 1'b0);
    chk32("t1_rdata_n3", rsp_rdata, 32'h0);
    @(negedge clk);
    chk1("t1_cmd_ready_n4", cmd_ready, 1'b1);

    // Read back with strobes forced low
    send(1'b0, 32'h1000, 32'h0, 4'hF, 3'd0, n);
    chk32("t2_pstrb_n1", {28'h0, b_pstrb}, 32'h0);
    @(negedge clk);
    chk32("t2_pstrb_n2", {28'h0, b_pstrb}, 32'h0);
    @(negedge clk);
    chk1("t2_rsp_valid_n3", rsp_valid, 1'b1);
    chk32("t2_rdata_n3", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Three wait states
    pready = 1'b0;
    send(1'b0, 32'h1000, 32'h0, 4'h0, 3'd0, n);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk32("t3_paddr_access", b_paddr, 32'h1000);
      chk1("t3_penable_access", b_penable, 1'b1);
      chk1("t3_rsp_valid_access", rsp_valid, 1'b0);
      if (c == 5) pready = 1'b1;
    end
    @(negedge clk);
    chk1("t3_rsp_valid_n6", rsp_valid, 1'b1);
    chk32("t3_rdata_n6", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Response back-pressure; a command offered meanwhile waits until IDLE
    rsp_ready = 1'b0;
    send(1'b1, 32'h1004, 32'h12345678, 4'h3, 3'd5, n);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1004; cmd_prot = 3'd1; cmd_strb = 4'h0;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      chk1("t4_rsp_valid_hold", rsp_valid, 1'b1);
      chk1("t4_cmd_ready_hold", cmd_ready, 1'b0);
      chk32("t4_rdata_hold", rsp_rdata, 32'h0);
      chk32("t4_pprot_hold", {29'h0, b_pprot}, 32'd5);
    end
    @(negedge clk);
    chk1("t4_rsp_valid_n8", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk1("t4_cmd_ready_n9", cmd_ready, 1'b1);
    chk1("t4_rsp_valid_n9", rsp_valid, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk1("t4_psel_n10", b_psel, 1'b1);
    chk1("t4_pwrite_n10", b_pwrite, 1'b0);
    chk32("t4_pprot_n10", {29'h0, b_pprot}, 32'd1);
    repeat (2) @(negedge clk);
    chk1("t4_rsp_valid_n12", rsp_valid, 1'b1);
    chk32("t4_rdata_strb", rsp_rdata, 32'h00005678);
    @(negedge clk);

    // Reset during ACCESS
    pready = 1'b0;
    send(1'b0, 32'h1000, 32'h0, 4'h0, 3'd0, n);
    @(negedge clk);
    chk1("t5_penable_n2", b_penable, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("t5_psel_rst", b_psel, 1'b0);
    chk1("t5_penable_rst", b_penable, 1'b0);
    chk1("t5_rsp_valid_rst", rsp_valid, 1'b0);
    chk1("t5_cmd_ready_rst", cmd_ready, 1'b0);
    rst = 1'b0; pready = 1'b1;
    @(negedge clk);
    chk1("t5_cmd_ready_rel", cmd_ready, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk1("t5_no_rsp", rsp_valid, 1'b0);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer stuck: abort after TO ACCESS cycles
    pready = 1'b0;
    send(1'b0, 32'h1000, 32'h0, 4'h0, 3'd0, n);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk1("t6_penable_access", b_penable, 1'b1);
      chk1("t6_rsp_valid_access", rsp_valid, 1'b0);
    end
    @(negedge clk);
    chk1("t6_rsp_valid", rsp_valid, 1'b1);
    chk1("t6_rsp_err", rsp_err, 1'b1);
    chk32("t6_rdata", rsp_rdata, 32'h0);
    chk1("t6_psel", b_psel, 1'b0);
    pready = 1'b1;
    @(negedge clk);
`endif

    // Normal write and read after everything else; rsp_err is clear again
    send(1'b1, 32'h1008, 32'hA5A5A5A5, 4'hF, 3'd3, n);
    repeat (2) @(negedge clk);
    chk1("t7_rsp_valid", rsp_valid, 1'b1);
    chk1("t7_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    send(1'b0, 32'h1008, 32'h0, 4'h0, 3'd0, n);
    repeat (2) @(negedge clk);
    chk32("t7_rdata", rsp_rdata, 32'hA5A5A5A5);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
